kinase_step_sequencer: RTL and testbench
========================================

# kinase_step_sequencer

Programmable step sequencer that drives the control-layer inputs of the dual `kinase_activity` array (`ctrl_a`, `ctrl_s`, `pump_a`, `pump_b`). It plays back a small table of valve states with dwell times, generating peristaltic pump phase patterns during each step. It sits between the host/command interface and the pad-wrapped chip, and is the sole driver of the shared control pins for both device instances.

## Interface

Parameters:
- `NSTEPS`, 16: step table depth; power of two.
- `PRESCALE`, 1000: clock cycles per dwell tick; ≥ 1.
- `DWELL_W`, 16: dwell field width in ticks.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `cfg_we` in 1: table write strobe.
- `cfg_addr` in log2(NSTEPS): table write address.
- `cfg_data` in 19+DWELL_W: step entry `{ctrl_a[12:0], ctrl_s[3:0], pa_en, pb_en, dwell}`, MSB first.
- `step_count` in log2(NSTEPS)+1: number of steps to run; sampled on accepted `start`.
- `start` in 1: run request pulse.
- `abort` in 1: stop request pulse.
- `ctrl_a` out 13: valve control, 1 = pressurized (closed).
- `ctrl_s` out 4: valve control.
- `pump_a` out 3: three-valve pump phases.
- `pump_b` out 2: two-valve pump phases.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse on normal completion.
- `aborted` out 1: one-cycle pulse on abort.
- `step_idx` out log2(NSTEPS): current step index.

## Operation

- FSM states: IDLE, RUN, DONE, ABORT.
- IDLE: all valve outputs 0. `start` with `step_count` ≠ 0 → RUN at step 0. `start` with `step_count` = 0 → DONE directly.
- RUN: registered outputs show the current entry. `ctrl_a`/`ctrl_s` come straight from the entry.
  - `pump_a`: when `pa_en`, cycles 011 → 110 → 101 → 011, advancing one phase per tick. When disabled, it is 000.
  - `pump_b`: when `pb_en`, alternates 01 → 10 per tick. When disabled, it is 00.
  - Pump phase and prescaler reset to phase 0 / count 0 at each step entry.
  - Dwell of 0 is treated as 1.
  - After `max(dwell,1)` ticks: if `step_idx` = `step_count`−1 → DONE, else `step_idx`+1 and load the next entry.
- DONE: one cycle. `done`=1, outputs 0 → IDLE.
- ABORT: entered on `abort` in RUN. One cycle. `aborted`=1, all valve outputs 0 → IDLE.
- `abort` in IDLE/DONE is ignored. `start` while not IDLE is ignored.
- Simultaneous `start`+`abort` in IDLE: `abort` wins and no run begins (`aborted` is not pulsed).
- `cfg_we` while `busy` is ignored (table unchanged). Writes in IDLE take effect for the next run.
- `step_count` > NSTEPS is clamped to NSTEPS.
- Reset: every output is 0, FSM is IDLE, counters are 0. Table contents after reset are undefined; software reloads.

## Timing

- `start` accepted at edge N → step 0 values appear on outputs after edge N+1 (one-cycle latency). `busy` rises at the same edge.
- Tick occurs when the prescaler reaches PRESCALE−1. Step k therefore lasts exactly `max(dwell_k,1)*PRESCALE` cycles.
- Pump phase changes on the edge following each tick within a step. No change occurs on the final tick, which loads the next step instead.
- Last step ends → DONE state for one cycle (`done`=1, `busy`=0) → IDLE.
- `abort` at edge M → outputs 0 and `aborted`=1 after edge M+1.
- `rst_n` low mid-run: immediate asynchronous clear of all outputs. No `done` or `aborted` pulse is produced.

## Structure

- Package `kinase_seq_pkg` holds:
  - Step-entry field widths and offsets (CTRL_A_W=13, CTRL_S_W=4, PUMP_A_W=3, PUMP_B_W=2).
  - FSM state enum.
  - Pump phase pattern constants (PA_PH0..2, PB_PH0..1).
- Sub-module `kinase_pump_phase` contains the prescaler, tick output, dwell counter and pump phase registers. It is cleared by a `step_load` pulse from the FSM.
- The table is a register array inside the top. No RAM macro is used.

## Test plan

- Basic run: PRESCALE=4. Load entry0 {ctrl_a=0x1FFF, ctrl_s=0x5, pumps off, dwell=2}. Start with step_count=1 → outputs 0x1FFF/0x5 for exactly 8 cycles, then `done` pulses once and outputs return to 0.
- Pump pattern: entry with pa_en=pb_en=1, dwell=4 → `pump_a` sequence 011, 110, 101, 011 and `pump_b` sequence 01, 10, 01, 10, each held for 4 cycles.
- Multi-step and dwell 0: three entries with dwell 1/0/3 and step_count=3 → `step_idx` 0, 1, 2 with lengths 4, 4, 12 cycles. Zero-length start → `done` without `busy`.
- Abort: abort during step 1 of 3 → `aborted` the next cycle, outputs 0, no `done`. A subsequent start restarts at step 0.
- Ignored events: `cfg_we` to the running entry mid-run → outputs unchanged. `start`+`abort` together in IDLE → stays IDLE. Second `start` while busy → no restart.
- Reset mid-run: drive `rst_n` low asynchronously between edges → all outputs 0 immediately. After release, state is IDLE with no pulses.

Source files
------------

// File: rtl/kinase_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : kinase_seq_pkg
// Purpose  : Shared definitions for the kinase step sequencer: step-entry
//            field layout, sequencer FSM state encoding and the peristaltic
//            pump phase patterns.
// Revision : 1.0 - initial release
// ============================================================================
package kinase_seq_pkg;

   // Step-entry field widths
   localparam int CTRL_A_W    = 13;
   localparam int CTRL_S_W    = 4;
   localparam int PUMP_A_W    = 3;
   localparam int PUMP_B_W    = 2;
   // Everything in an entry above the dwell field
   localparam int ENTRY_HDR_W = CTRL_A_W + CTRL_S_W + 2;

   // Field offsets measured from bit 0 of the header (i.e. above dwell)
   localparam int OFS_PB_EN   = 0;
   localparam int OFS_PA_EN   = 1;
   localparam int OFS_CTRL_S  = 2;
   localparam int OFS_CTRL_A  = OFS_CTRL_S + CTRL_S_W;

   // Header part of a step entry, MSB first
   typedef struct packed {
      logic [CTRL_A_W-1:0] ctrl_a;
      logic [CTRL_S_W-1:0] ctrl_s;
      logic                pa_en;
      logic                pb_en;
   } step_hdr_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DONE  = 2'd2,
      ST_ABORT = 2'd3
   } seq_state_t;

   // Three-valve pump: one valve open per phase, rotating
   localparam logic [PUMP_A_W-1:0] PA_PH0 = 3'b011;
   localparam logic [PUMP_A_W-1:0] PA_PH1 = 3'b110;
   localparam logic [PUMP_A_W-1:0] PA_PH2 = 3'b101;
   // Two-valve pump: alternating
   localparam logic [PUMP_B_W-1:0] PB_PH0 = 2'b01;
   localparam logic [PUMP_B_W-1:0] PB_PH1 = 2'b10;

   function automatic logic [PUMP_A_W-1:0] pa_pattern(input logic [1:0] ph);
      logic [PUMP_A_W-1:0] pat;
      case (ph)
         2'd0:    pat = PA_PH0;
         2'd1:    pat = PA_PH1;
         2'd2:    pat = PA_PH2;
         default: pat = PA_PH0;
      endcase
      return pat;
   endfunction

endpackage : kinase_seq_pkg
`default_nettype wire

// File: rtl/kinase_pump_phase.sv
`default_nettype none
// ============================================================================
// Module   : kinase_pump_phase
// Purpose  : Dwell timing and pump phase generation for one sequencer step.
//            A prescaler produces a tick every PRESCALE cycles of RUN; ticks
//            are counted against the step's dwell, and each non-final tick
//            advances the pump phases.
// Ports    : clk, rst_n      - clock, async active-low reset
//            run             - sequencer is in RUN (counters advance)
//            step_load       - entering a new step: clear all counters
//            dwell           - dwell of the current entry in ticks (0 == 1)
//            pa_en, pb_en    - pump enables of the current entry
//            tick            - prescaler wraps this cycle
//            dwell_last      - current tick interval is the step's last one
//            pa_pat, pb_pat  - pump valve patterns (zero when disabled)
// Revision : 1.0 - initial release
// ============================================================================
module kinase_pump_phase
   import kinase_seq_pkg::*;
#(
   parameter int PRESCALE = 1000,
   parameter int DWELL_W  = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                run,
   input  logic                step_load,
   input  logic [DWELL_W-1:0]  dwell,
   input  logic                pa_en,
   input  logic                pb_en,
   output logic                tick,
   output logic                dwell_last,
   output logic [PUMP_A_W-1:0] pa_pat,
   output logic [PUMP_B_W-1:0] pb_pat
);

   localparam int              PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

   logic [PS_W-1:0]    presc;
   logic [DWELL_W-1:0] dwell_cnt;
   logic [DWELL_W-1:0] dwell_m1;
   logic [1:0]         pa_ph;
   logic               pb_ph;

   // A zero dwell behaves as a single tick
   assign dwell_m1   = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
   assign tick       = run && (presc == PS_MAX);
   assign dwell_last = (dwell_cnt == dwell_m1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc     <= '0;
         dwell_cnt <= '0;
         pa_ph     <= 2'd0;
         pb_ph     <= 1'b0;
      end else if (step_load) begin
         presc     <= '0;
         dwell_cnt <= '0;
         pa_ph     <= 2'd0;
         pb_ph     <= 1'b0;
      end else if (run) begin
         if (presc == PS_MAX) begin
            presc <= '0;
            // The final tick hands over to the next step instead of
            // advancing the pumps.
            if (!dwell_last) begin
               dwell_cnt <= dwell_cnt + DWELL_W'(1);
               pa_ph     <= (pa_ph == 2'd2) ? 2'd0 : pa_ph + 2'd1;
               pb_ph     <= ~pb_ph;
            end
         end else begin
            presc <= presc + PS_W'(1);
         end
      end
   end

   assign pa_pat = pa_en ? pa_pattern(pa_ph) : '0;
   assign pb_pat = pb_en ? (pb_ph ? PB_PH1 : PB_PH0) : '0;

endmodule : kinase_pump_phase
`default_nettype wire

// File: rtl/kinase_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : kinase_step_sequencer
// Purpose  : Plays back a table of valve states with dwell times and drives
//            the shared control pins (ctrl_a, ctrl_s, pump_a, pump_b) of the
//            kinase_activity array. All outputs are registered from the
//            current FSM state, so they trail the state by one cycle.
// Ports    : clk, rst_n            - clock, async active-low reset
//            cfg_we/addr/data      - step table write (ignored unless idle)
//            step_count            - steps to run, sampled on accepted start
//            start, abort          - run / stop request pulses
//            ctrl_a, ctrl_s        - valve controls (1 = pressurized)
//            pump_a, pump_b        - pump phase patterns
//            busy, done, aborted   - run status and completion pulses
//            step_idx              - current step index
// Revision : 1.0 - initial release
// ============================================================================
module kinase_step_sequencer
   import kinase_seq_pkg::*;
#(
   parameter int NSTEPS   = 16,
   parameter int PRESCALE = 1000,
   parameter int DWELL_W  = 16
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              cfg_we,
   input  logic [$clog2(NSTEPS)-1:0]         cfg_addr,
   input  logic [ENTRY_HDR_W+DWELL_W-1:0]    cfg_data,
   input  logic [$clog2(NSTEPS):0]           step_count,
   input  logic                              start,
   input  logic                              abort,
   output logic [CTRL_A_W-1:0]               ctrl_a,
   output logic [CTRL_S_W-1:0]               ctrl_s,
   output logic [PUMP_A_W-1:0]               pump_a,
   output logic [PUMP_B_W-1:0]               pump_b,
   output logic                              busy,
   output logic                              done,
   output logic                              aborted,
   output logic [$clog2(NSTEPS)-1:0]         step_idx
);

   localparam int IDX_W   = $clog2(NSTEPS);
   localparam int CNT_W   = IDX_W + 1;
   localparam int ENTRY_W = ENTRY_HDR_W + DWELL_W;

   logic [ENTRY_W-1:0] table_q [NSTEPS];

   seq_state_t         state, state_nx;
   logic [IDX_W-1:0]   idx, idx_nx;
   logic [CNT_W-1:0]   cnt_q, cnt_nx;
   logic [CNT_W-1:0]   count_clamped;
   logic               step_load;
   logic               step_end;
   logic               last_step;
   logic               running;

   logic [ENTRY_W-1:0] cur_entry;
   step_hdr_t          hdr;
   logic [DWELL_W-1:0] cur_dwell;

   logic               tick;
   logic               dwell_last;
   logic [PUMP_A_W-1:0] pa_pat;
   logic [PUMP_B_W-1:0] pb_pat;

   assign cur_entry = table_q[idx];
   assign hdr       = cur_entry[ENTRY_W-1 -: ENTRY_HDR_W];
   assign cur_dwell = cur_entry[DWELL_W-1:0];
   assign running   = (state == ST_RUN);

   assign count_clamped = (step_count > CNT_W'(NSTEPS)) ? CNT_W'(NSTEPS) : step_count;
   // cnt_q is at least 1 whenever this is consulted (RUN only)
   assign last_step     = ({1'b0, idx} == (cnt_q - CNT_W'(1)));
   assign step_end      = tick && dwell_last;

   // ------------------------------------------------------------------
   // Step table: plain register array, writable only while idle
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (cfg_we && (state == ST_IDLE)) begin
         table_q[cfg_addr] <= cfg_data;
      end
   end

   // ------------------------------------------------------------------
   // Dwell / pump phase engine
   // ------------------------------------------------------------------
   kinase_pump_phase #(
      .PRESCALE (PRESCALE),
      .DWELL_W  (DWELL_W)
   ) u_pump (
      .clk        (clk),
      .rst_n      (rst_n),
      .run        (running),
      .step_load  (step_load),
      .dwell      (cur_dwell),
      .pa_en      (hdr.pa_en),
      .pb_en      (hdr.pb_en),
      .tick       (tick),
      .dwell_last (dwell_last),
      .pa_pat     (pa_pat),
      .pb_pat     (pb_pat)
   );

   // ------------------------------------------------------------------
   // Sequencer FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         idx   <= '0;
         cnt_q <= '0;
      end else begin
         state <= state_nx;
         idx   <= idx_nx;
         cnt_q <= cnt_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      idx_nx    = idx;
      cnt_nx    = cnt_q;
      step_load = 1'b0;
      case (state)
         ST_IDLE: begin
            // abort alongside start cancels the request silently
            if (start && !abort) begin
               cnt_nx = count_clamped;
               idx_nx = '0;
               if (count_clamped == '0) begin
                  state_nx = ST_DONE;
               end else begin
                  state_nx  = ST_RUN;
                  step_load = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_nx = ST_ABORT;
            end else if (step_end) begin
               if (last_step) begin
                  state_nx = ST_DONE;
               end else begin
                  idx_nx    = idx + IDX_W'(1);
                  step_load = 1'b1;
               end
            end
         end
         ST_DONE:  state_nx = ST_IDLE;
         ST_ABORT: state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Registered outputs, derived from the current state
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_a   <= '0;
         ctrl_s   <= '0;
         pump_a   <= '0;
         pump_b   <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         aborted  <= 1'b0;
         step_idx <= '0;
      end else begin
         ctrl_a   <= running ? hdr.ctrl_a : '0;
         ctrl_s   <= running ? hdr.ctrl_s : '0;
         pump_a   <= running ? pa_pat     : '0;
         pump_b   <= running ? pb_pat     : '0;
         busy     <= running;
         done     <= (state == ST_DONE);
         aborted  <= (state == ST_ABORT);
         step_idx <= idx;
      end
   end

endmodule : kinase_step_sequencer
`default_nettype wire

// File: tb/tb_kinase_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_kinase_step_sequencer
// Purpose  : Self-checking bench for kinase_step_sequencer. A reference model
//            expands the step table into the expected per-cycle output trace
//            directly from the dwell / pump-phase rules and compares it with
//            the DUT cycle by cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_kinase_step_sequencer;

   localparam int NST     = 16;
   localparam int PS      = 4;
   localparam int DW      = 16;
   localparam int ENTRY_W = 19 + DW;

   typedef logic [28:0] vec_t;

   logic                clk;
   logic                rst_n;
   logic                cfg_we;
   logic [3:0]          cfg_addr;
   logic [ENTRY_W-1:0]  cfg_data;
   logic [4:0]          step_count;
   logic                start;
   logic                abort;
   logic [12:0]         ctrl_a;
   logic [3:0]          ctrl_s;
   logic [2:0]          pump_a;
   logic [1:0]          pump_b;
   logic                busy;
   logic                done;
   logic                aborted;
   logic [3:0]          step_idx;

   kinase_step_sequencer #(
      .NSTEPS   (NST),
      .PRESCALE (PS),
      .DWELL_W  (DW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_we     (cfg_we),
      .cfg_addr   (cfg_addr),
      .cfg_data   (cfg_data),
      .step_count (step_count),
      .start      (start),
      .abort      (abort),
      .ctrl_a     (ctrl_a),
      .ctrl_s     (ctrl_s),
      .pump_a     (pump_a),
      .pump_b     (pump_b),
      .busy       (busy),
      .done       (done),
      .aborted    (aborted),
      .step_idx   (step_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model state
   logic [ENTRY_W-1:0] mtab [NST];
   logic [2:0]         pa_seq [3];
   logic [1:0]         pb_seq [2];
   vec_t               exp_q [$];
   int                 total;
   int                 bad;

   // step_idx is only meaningful while busy
   function automatic vec_t mkvec(input logic [12:0] a, input logic [3:0] s,
                                  input logic [2:0] pa, input logic [1:0] pb,
                                  input logic b, input logic d, input logic ab,
                                  input logic [3:0] ix);
      return {a, s, pa, pb, b, d, ab, (b ? ix : 4'd0)};
   endfunction

   function automatic vec_t obs();
      return mkvec(ctrl_a, ctrl_s, pump_a, pump_b, busy, done, aborted, step_idx);
   endfunction

   task automatic chk(input string tag, input vec_t o, input vec_t e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   // Expand the table into the expected output trace of one run, followed
   // by the done cycle.
   task automatic build_trace(input int cnt_req);
      int n;
      int d;
      logic [ENTRY_W-1:0] e;
      logic [2:0] pa;
      logic [1:0] pb;
      n = (cnt_req > NST) ? NST : cnt_req;
      exp_q.delete();
      for (int k = 0; k < n; k++) begin
         e = mtab[k];
         d = (e[15:0] == 16'd0) ? 1 : int'(e[15:0]);
         for (int j = 0; j < d; j++) begin
            pa = e[17] ? pa_seq[j % 3] : 3'b000;
            pb = e[16] ? pb_seq[j % 2] : 2'b00;
            for (int p = 0; p < PS; p++)
               exp_q.push_back(mkvec(e[34:22], e[21:18], pa, pb, 1'b1, 1'b0, 1'b0, 4'(k)));
         end
      end
      exp_q.push_back(mkvec('0, '0, '0, '0, 1'b0, 1'b1, 1'b0, '0));
   endtask

   task automatic cfg_write(input int addr, input logic [ENTRY_W-1:0] data);
      @(negedge clk);
      cfg_we   = 1'b1;
      cfg_addr = 4'(addr);
      cfg_data = data;
      @(negedge clk);
      cfg_we   = 1'b0;
      mtab[addr] = data;
   endtask

   function automatic logic [ENTRY_W-1:0] rand_entry(input int max_dwell);
      logic [ENTRY_W-1:0] e;
      e = {13'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
           16'($urandom_range(0, max_dwell))};
      return e;
   endfunction

   // One run: abort_at / disturb_at are trace indices (-1 = none). The
   // disturbance writes the running entry and re-pulses start, both of
   // which must be ignored.
   task automatic run_seq(input int cnt_req, input int abort_at,
                          input int disturb_at, input string tag);
      build_trace(cnt_req);
      @(negedge clk);
      step_count = 5'(cnt_req);
      start      = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk({tag, "_accept"}, obs(), '0);
      for (int i = 0; i < exp_q.size(); i++) begin
         @(posedge clk);
         #1;
         start  = 1'b0;
         cfg_we = 1'b0;
         chk(tag, obs(), exp_q[i]);
         if (i == abort_at) begin
            abort = 1'b1;
            @(posedge clk);
            #1;
            abort = 1'b0;
            chk({tag, "_abort_edge"}, obs(), exp_q[i+1]);
            @(posedge clk);
            #1;
            chk({tag, "_aborted"}, obs(), mkvec('0, '0, '0, '0, 1'b0, 1'b0, 1'b1, '0));
            break;
         end
         if (i == disturb_at) begin
            cfg_we     = 1'b1;
            cfg_addr   = exp_q[i+1][3:0];
            cfg_data   = ~mtab[exp_q[i+1][3:0]];
            start      = 1'b1;
            step_count = 5'd1;
         end
      end
      @(posedge clk);
      #1;
      chk({tag, "_idle"}, obs(), '0);
   endtask

   initial begin
      int n;
      total = 0;
      bad   = 0;
      pa_seq[0] = 3'b011; pa_seq[1] = 3'b110; pa_seq[2] = 3'b101;
      pb_seq[0] = 2'b01;  pb_seq[1] = 2'b10;
      for (int k = 0; k < NST; k++) mtab[k] = '0;
      rst_n      = 1'b0;
      cfg_we     = 1'b0;
      cfg_addr   = '0;
      cfg_data   = '0;
      step_count = '0;
      start      = 1'b0;
      abort      = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("reset", obs(), '0);
      chk("reset_idx", {25'd0, step_idx}, '0);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic run
      cfg_write(0, {13'h1FFF, 4'h5, 1'b0, 1'b0, 16'd2});
      run_seq(1, -1, -1, "basic");

      // Pump patterns
      cfg_write(0, {13'h0AA, 4'h3, 1'b1, 1'b1, 16'd4});
      run_seq(1, -1, -1, "pump");

      // Multi-step with dwell 1 / 0 / 3
      cfg_write(0, {13'h1234, 4'h1, 1'b1, 1'b0, 16'd1});
      cfg_write(1, {13'h0F0F, 4'h2, 1'b0, 1'b1, 16'd0});
      cfg_write(2, {13'h1555, 4'hC, 1'b1, 1'b1, 16'd3});
      run_seq(3, -1, -1, "multi");

      // Zero-length start
      run_seq(0, -1, -1, "zero");

      // Abort in step 1, then a fresh run from step 0
      run_seq(3, 5, -1, "abort");
      run_seq(3, -1, -1, "restart");

      // Table write and second start while running are ignored
      run_seq(3, -1, 5, "ignore");
      run_seq(3, -1, -1, "ignore_tbl");

      // start + abort together in IDLE
      @(negedge clk);
      step_count = 5'd3;
      start      = 1'b1;
      abort      = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("start_abort_idle", obs(), '0);
      end

      // step_count above NSTEPS is clamped
      for (int k = 0; k < NST; k++) cfg_write(k, rand_entry(1));
      run_seq(20, -1, -1, "clamp");

      // Randomised tables
      for (int r = 0; r < 5; r++) begin
         n = $urandom_range(1, 5);
         for (int k = 0; k < n; k++) cfg_write(k, rand_entry(3));
         run_seq(n, -1, -1, "rand");
      end

      // Asynchronous reset mid-run
      @(negedge clk);
      step_count = 5'd3;
      start      = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("rst_async", obs(), '0);
      chk("rst_async_idx", {25'd0, step_idx}, '0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("post_rst_idle", obs(), '0);
         chk("post_rst_idx", {25'd0, step_idx}, '0);
      end
      run_seq(3, -1, -1, "post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_kinase_step_sequencer
`default_nettype wire
